// File: rtl/rally_pkg.sv
// Shared types and constants for the rally controller.
package rally_pkg;

    localparam int SCORE_W   = 7;
    localparam int SCORE_MAX = 99;
    localparam int PAUSE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_SCORED    = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_GAME_OVER = 3'd5
    } rally_state_e;

endpackage

// File: rtl/score_counter.sv
// Saturating player score register with increment and clear.
module score_counter
    import rally_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic               clr_i,
    output logic [SCORE_W-1:0] count_o
);

    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(SCORE_MAX);

    logic [SCORE_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + SCORE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rally_controller.sv
// Pong rally sequencer: serve, play, score, pause and game-over handling.
module rally_controller
    import rally_pkg::*;
#(
    parameter int ball_x_coords_width = 10,
    parameter int x_coords_min        = 0,
    parameter int x_coords_max        = 639,
    parameter int WIN_SCORE           = 11,
    parameter int PAUSE_FRAMES        = 60
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           frame_tick,
    input  logic [ball_x_coords_width-1:0] ball_x_coords,
    output logic                           ball_enable,
    output logic                           ball_recenter,
    output logic                           serve_dir,
    output logic [SCORE_W-1:0]             score1,
    output logic [SCORE_W-1:0]             score2,
    output logic                           point_p1,
    output logic                           point_p2,
    output logic                           game_over,
    output logic                           winner
);

    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    rally_state_e       state_q, state_d;
    logic [PAUSE_W-1:0] cnt_q, cnt_d;
    logic enable_q, enable_d;
    logic recenter_q, recenter_d;
    logic dir_q, dir_d;
    logic p1_q, p1_d;
    logic p2_q, p2_d;
    logic over_q, over_d;
    logic winner_q, winner_d;
    logic inc1, inc2, clr;
    logic exit_left, exit_right;
    logic signed [31:0] x_ext;

    // Signed compare keeps x_coords_min = 0 meaningful without a constant test.
    assign x_ext      = $signed(32'(ball_x_coords));
    assign exit_left  = x_ext < x_coords_min;
    assign exit_right = x_ext > x_coords_max;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        recenter_d = 1'b0;
        p1_d       = 1'b0;
        p2_d       = 1'b0;
        dir_d      = dir_q;
        winner_d   = winner_q;
        inc1       = 1'b0;
        inc2       = 1'b0;
        clr        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SERVE;
                    recenter_d = 1'b1;
                    dir_d      = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (exit_left) begin
                    state_d    = ST_SCORED;
                    inc1       = 1'b1;
                    p1_d       = 1'b1;
                    dir_d      = 1'b0;
                    winner_d   = 1'b0;
                    recenter_d = 1'b1;
                end else if (exit_right) begin
                    state_d    = ST_SCORED;
                    inc2       = 1'b1;
                    p2_d       = 1'b1;
                    dir_d      = 1'b1;
                    winner_d   = 1'b1;
                    recenter_d = 1'b1;
                end
            end
            ST_SCORED: begin
                if ((score1 == WIN_VAL) || (score2 == WIN_VAL)) begin
                    state_d = ST_GAME_OVER;
                end else begin
                    state_d = ST_PAUSE;
                    cnt_d   = '0;
                end
            end
            ST_PAUSE: begin
                if (frame_tick) begin
                    cnt_d = cnt_q + PAUSE_W'(1);
                    if (cnt_d == PAUSE_LAST) state_d = ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    state_d    = ST_SERVE;
                    clr        = 1'b1;
                    recenter_d = 1'b1;
                    dir_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        enable_d = (state_d == ST_PLAY);
        over_d   = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            enable_q   <= 1'b0;
            recenter_q <= 1'b0;
            dir_q      <= 1'b1;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            enable_q   <= enable_d;
            recenter_q <= recenter_d;
            dir_q      <= dir_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
        end
    end

    score_counter u_score1 (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (inc1),
        .clr_i   (clr),
        .count_o (score1)
    );

    score_counter u_score2 (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (inc2),
        .clr_i   (clr),
        .count_o (score2)
    );

    assign ball_enable   = enable_q;
    assign ball_recenter = recenter_q;
    assign serve_dir     = dir_q;
    assign point_p1      = p1_q;
    assign point_p2      = p2_q;
    assign game_over     = over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_rally_controller.sv
// Bench for rally_controller: two parameterisations driven in lockstep against a rule-level model.
module tb_rally_controller;

    localparam int XMIN = 16;
    localparam int XMAX = 600;
    localparam int XIN  = 300;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_SCORED = 3;
    localparam int P_PAUSE = 4;
    localparam int P_OVER  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, frame_tick;
    logic [9:0] ball_x;

    logic       en_a, rc_a, dir_a, p1_a, p2_a, go_a, win_a;
    logic [6:0] s1_a, s2_a;
    logic       en_b, rc_b, dir_b, p1_b, p2_b, go_b, win_b;
    logic [6:0] s1_b, s2_b;

    int vectors = 0;
    int miscompares = 0;

    int m_ph[2], m_s1[2], m_s2[2], m_cnt[2];
    bit m_en[2], m_rc[2], m_dir[2], m_p1[2], m_p2[2], m_go[2], m_win[2];

    rally_controller #(
        .ball_x_coords_width(10), .x_coords_min(XMIN), .x_coords_max(XMAX),
        .WIN_SCORE(2), .PAUSE_FRAMES(3)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .ball_x_coords(ball_x), .ball_enable(en_a), .ball_recenter(rc_a),
        .serve_dir(dir_a), .score1(s1_a), .score2(s2_a), .point_p1(p1_a),
        .point_p2(p2_a), .game_over(go_a), .winner(win_a)
    );

    rally_controller #(
        .ball_x_coords_width(10), .x_coords_min(XMIN), .x_coords_max(XMAX),
        .WIN_SCORE(99), .PAUSE_FRAMES(1)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .ball_x_coords(ball_x), .ball_enable(en_b), .ball_recenter(rc_b),
        .serve_dir(dir_b), .score1(s1_b), .score2(s2_b), .point_p1(p1_b),
        .point_p2(p2_b), .game_over(go_b), .winner(win_b)
    );

    function automatic int win_of(input int i);
        return (i == 0) ? 2 : 99;
    endfunction

    function automatic int pf_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    // Rule-level model of what each game sees after this clock edge.
    task automatic model_update();
        int xv;
        xv = int'(ball_x);
        for (int i = 0; i < 2; i++) begin
            m_rc[i] = 1'b0;
            m_p1[i] = 1'b0;
            m_p2[i] = 1'b0;
            if (reset) begin
                m_ph[i] = P_IDLE; m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0;
                m_dir[i] = 1'b1; m_win[i] = 1'b0;
            end else begin
                case (m_ph[i])
                    P_IDLE: if (start) begin
                        m_ph[i] = P_SERVE; m_rc[i] = 1'b1; m_dir[i] = 1'b1;
                    end
                    P_SERVE: if (frame_tick) m_ph[i] = P_PLAY;
                    P_PLAY: begin
                        if (xv < XMIN) begin
                            m_s1[i] = (m_s1[i] >= 99) ? 99 : m_s1[i] + 1;
                            m_p1[i] = 1'b1; m_dir[i] = 1'b0; m_win[i] = 1'b0;
                            m_rc[i] = 1'b1; m_ph[i] = P_SCORED;
                        end else if (xv > XMAX) begin
                            m_s2[i] = (m_s2[i] >= 99) ? 99 : m_s2[i] + 1;
                            m_p2[i] = 1'b1; m_dir[i] = 1'b1; m_win[i] = 1'b1;
                            m_rc[i] = 1'b1; m_ph[i] = P_SCORED;
                        end
                    end
                    P_SCORED: begin
                        if (m_s1[i] == win_of(i) || m_s2[i] == win_of(i)) begin
                            m_ph[i] = P_OVER;
                        end else begin
                            m_ph[i] = P_PAUSE; m_cnt[i] = 0;
                        end
                    end
                    P_PAUSE: if (frame_tick) begin
                        m_cnt[i] = m_cnt[i] + 1;
                        if (m_cnt[i] == pf_of(i)) m_ph[i] = P_SERVE;
                    end
                    default: if (start) begin
                        m_s1[i] = 0; m_s2[i] = 0; m_ph[i] = P_SERVE;
                        m_rc[i] = 1'b1; m_dir[i] = 1'b1;
                    end
                endcase
            end
            m_en[i] = (m_ph[i] == P_PLAY);
            m_go[i] = (m_ph[i] == P_OVER);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit tk, input int x);
        reset = rst;
        start = st;
        frame_tick = tk;
        ball_x = 10'(x);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, XIN);
        step(1, 1, 1, XMAX + 1);
        vectors++; if (en_a !== 1'b0) begin miscompares++; $display("FAIL rst_enable got %b exp 0", en_a); end
        vectors++; if (rc_a !== 1'b0) begin miscompares++; $display("FAIL rst_recenter got %b exp 0", rc_a); end
        vectors++; if (dir_a !== 1'b1) begin miscompares++; $display("FAIL rst_serve_dir got %b exp 1", dir_a); end
        vectors++; if (s1_a !== 7'd0) begin miscompares++; $display("FAIL rst_score1 got %0d exp 0", s1_a); end
        vectors++; if (s2_a !== 7'd0) begin miscompares++; $display("FAIL rst_score2 got %0d exp 0", s2_a); end
        vectors++; if ({p1_a, p2_a} !== 2'b00) begin miscompares++; $display("FAIL rst_points got %b exp 00", {p1_a, p2_a}); end
        vectors++; if (go_a !== 1'b0) begin miscompares++; $display("FAIL rst_game_over got %b exp 0", go_a); end
        vectors++; if (win_a !== 1'b0) begin miscompares++; $display("FAIL rst_winner got %b exp 0", win_a); end
    endtask

    task automatic test_start_serve();
        step(0, 1, 0, XIN);
        vectors++; if ({rc_a, en_a} !== 2'b10) begin miscompares++; $display("FAIL serve_recenter got %b exp 10", {rc_a, en_a}); end
        step(0, 0, 0, XIN);
        vectors++; if (rc_a !== 1'b0) begin miscompares++; $display("FAIL serve_single_pulse got %b exp 0", rc_a); end
        step(0, 0, 1, XIN);
        vectors++; if ({en_a, en_b} !== 2'b11) begin miscompares++; $display("FAIL serve_to_play got %b exp 11", {en_a, en_b}); end
    endtask

    task automatic test_left_exit();
        int np = 0;
        int nr = 0;
        repeat (50) begin
            step(0, 0, 0, XMIN - 1);
            np += int'(p1_a);
            nr += int'(rc_a);
        end
        vectors++; if (np != 1) begin miscompares++; $display("FAIL left_point_pulses got %0d exp 1", np); end
        vectors++; if (nr != 1) begin miscompares++; $display("FAIL left_recenter_pulses got %0d exp 1", nr); end
        vectors++; if (s1_a !== 7'd1 || s2_a !== 7'd0) begin miscompares++; $display("FAIL left_scores got %0d/%0d exp 1/0", s1_a, s2_a); end
        vectors++; if (dir_a !== 1'b0) begin miscompares++; $display("FAIL left_serve_dir got %b exp 0", dir_a); end
    endtask

    task automatic test_pause();
        for (int k = 1; k <= 4; k++) begin
            repeat (4) step(0, 0, 0, XIN);
            step(0, 0, 1, XIN);
            vectors++;
            if (en_a !== (k == 4)) begin
                miscompares++;
                $display("FAIL pause_tick%0d_enable got %b exp %b", k, en_a, (k == 4));
            end
        end
    endtask

    task automatic test_win();
        repeat (3) step(0, 0, 0, XMAX + 1);
        vectors++; if (s2_a !== 7'd1 || go_a !== 1'b0) begin miscompares++; $display("FAIL win_first_point got %0d go %b exp 1 go 0", s2_a, go_a); end
        repeat (4) begin
            repeat (4) step(0, 0, 0, XIN);
            step(0, 0, 1, XIN);
        end
        vectors++; if (en_a !== 1'b1) begin miscompares++; $display("FAIL win_back_in_play got %b exp 1", en_a); end
        repeat (3) step(0, 0, 0, XMAX + 1);
        vectors++; if (s2_a !== 7'd2 || s1_a !== 7'd1) begin miscompares++; $display("FAIL win_scores got %0d/%0d exp 1/2", s1_a, s2_a); end
        vectors++; if ({go_a, win_a} !== 2'b11) begin miscompares++; $display("FAIL win_game_over got %b exp 11", {go_a, win_a}); end
        vectors++; if (en_a !== 1'b0) begin miscompares++; $display("FAIL win_ball_stopped got %b exp 0", en_a); end
        step(0, 1, 0, XIN);
        vectors++; if (s1_a !== 7'd0 || s2_a !== 7'd0) begin miscompares++; $display("FAIL restart_scores got %0d/%0d exp 0/0", s1_a, s2_a); end
        vectors++; if ({rc_a, go_a, dir_a} !== 3'b101) begin miscompares++; $display("FAIL restart_flags got %b exp 101", {rc_a, go_a, dir_a}); end
        step(0, 0, 1, XIN);
        vectors++; if (en_a !== 1'b1) begin miscompares++; $display("FAIL restart_play got %b exp 1", en_a); end
    endtask

    task automatic test_reset_exit();
        step(1, 0, 0, XMAX + 1);
        vectors++; if (s2_a !== 7'd0 || p2_a !== 1'b0) begin miscompares++; $display("FAIL rstexit_no_point got %0d p2 %b exp 0 p2 0", s2_a, p2_a); end
        vectors++; if ({en_a, rc_a, go_a} !== 3'b000) begin miscompares++; $display("FAIL rstexit_flags got %b exp 000", {en_a, rc_a, go_a}); end
        step(0, 0, 1, XMAX + 1);
        vectors++; if ({en_a, p2_a, rc_a} !== 3'b000) begin miscompares++; $display("FAIL rstexit_idle got %b exp 000", {en_a, p2_a, rc_a}); end
        vectors++; if (s2_a !== 7'd0) begin miscompares++; $display("FAIL rstexit_idle_score got %0d exp 0", s2_a); end
    endtask

    task automatic test_random();
        logic [19:0] obs, exp;
        logic        wobs;
        int          x;
        step(1, 0, 0, XIN);
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(15))
                0: x = $urandom_range(XMIN - 1);
                1: x = $urandom_range(1023, XMAX + 1);
                default: x = $urandom_range(XMAX, XMIN);
            endcase
            step($urandom_range(199) == 0, $urandom_range(29) == 0,
                 $urandom_range(3) == 0, x);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    obs  = {en_a, rc_a, dir_a, s1_a, s2_a, p1_a, p2_a, go_a};
                    wobs = win_a;
                end else begin
                    obs  = {en_b, rc_b, dir_b, s1_b, s2_b, p1_b, p2_b, go_b};
                    wobs = win_b;
                end
                exp = {m_en[i], m_rc[i], m_dir[i], 7'(m_s1[i]), 7'(m_s2[i]),
                       m_p1[i], m_p2[i], m_go[i]};
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL rand_outputs dut%0d cyc %0d got %h exp %h", i, n, obs, exp);
                end
                if (m_go[i]) begin
                    vectors++;
                    if (wobs !== m_win[i]) begin
                        miscompares++;
                        $display("FAIL rand_winner dut%0d cyc %0d got %b exp %b", i, n, wobs, m_win[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_saturate();
        step(1, 0, 0, XIN);
        step(0, 1, 0, XIN);
        for (int k = 0; k < 99; k++) begin
            step(0, 0, 1, XIN);
            step(0, 0, 0, XMIN - 1);
            vectors++;
            if (s1_b !== 7'(m_s1[1]) || p1_b !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_point%0d got %0d p1 %b exp %0d p1 1", k + 1, s1_b, p1_b, m_s1[1]);
            end
            step(0, 0, 0, XIN);
            step(0, 0, 1, XIN);
        end
        vectors++; if (s1_b !== 7'd99) begin miscompares++; $display("FAIL sat_score got %0d exp 99", s1_b); end
        vectors++; if ({go_b, win_b} !== 2'b10) begin miscompares++; $display("FAIL sat_game_over got %b exp 10", {go_b, win_b}); end
        repeat (10) begin
            step(0, 0, 1, XMIN - 1);
            step(0, 0, 0, XMAX + 1);
        end
        vectors++; if (s1_b !== 7'd99 || s2_b !== 7'd0) begin miscompares++; $display("FAIL sat_no_wrap got %0d/%0d exp 99/0", s1_b, s2_b); end
        vectors++; if ({go_b, p1_b, en_b} !== 3'b100) begin miscompares++; $display("FAIL sat_frozen got %b exp 100", {go_b, p1_b, en_b}); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        frame_tick = 1'b0;
        ball_x = 10'(XIN);
        test_reset();
        test_start_serve();
        test_left_exit();
        test_pause();
        test_win();
        test_reset_exit();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rally_controller.md
RALLY_CONTROLLER -- requirements
Module: rally_controller

Interface
REQ-001 Parameter ball_x_coords_width, default 10, is the width of the ball x coordinate.
REQ-002 Parameter x_coords_min, default 0; a ball x strictly below it is a left exit and a point for player 1.
REQ-003 Parameter x_coords_max, default 639; a ball x strictly above it is a right exit and a point for player 2.
REQ-004 Parameter WIN_SCORE, default 11, range 1..99, is the score that ends the game.
REQ-005 Parameter PAUSE_FRAMES, default 60, range 1..255, is the number of frame_tick pulses held after a point.
REQ-006 clk  in  1  is the single clock; reset is synchronous and active-high.
REQ-007 reset  in  1  is the synchronous, active-high reset, sampled on clk rising edge.
REQ-008 start  in  1  is a level input; high requests a game start or restart.
REQ-009 frame_tick  in  1  is a one-cycle pulse per video frame.
REQ-010 ball_x_coords  in  ball_x_coords_width  is the current ball x position.
REQ-011 ball_enable  out  1  is high while the ball may move (PLAY only).
REQ-012 ball_recenter  out  1  is a one-cycle pulse commanding the ball logic to re-centre.
REQ-013 serve_dir  out  1  gives the serve direction: 0 = toward left, 1 = toward right.
REQ-014 score1, score2  out  7 each  are unsigned scores, 0..99.
REQ-015 point_p1, point_p2  out  1 each  are one-cycle pulses, one per awarded point.
REQ-016 game_over  out  1  is high in GAME_OVER.
REQ-017 winner  out  1  is valid when game_over is high: 0 = player 1, 1 = player 2.

Function
REQ-018 The FSM SHALL have the states IDLE, SERVE, PLAY, SCORED, PAUSE and GAME_OVER.
- IDLE->SERVE: start=1.
- SERVE->PLAY: next frame_tick.
- PLAY->SCORED: left or right exit sampled.
- SCORED->GAME_OVER: the updated score equals WIN_SCORE.
- SCORED->PAUSE: otherwise.
- PAUSE->SERVE: PAUSE_FRAMES frame_ticks counted.
- GAME_OVER->SERVE: start=1; scores clear and the game restarts.
REQ-019 Exits SHALL be evaluated only in PLAY, and exactly one point SHALL be awarded per exit regardless of how many cycles the ball stays outside.
REQ-020 Left and right exit asserted together SHALL be impossible by parameters; if it occurs, the left exit wins.
REQ-021 On the PLAY->SCORED edge, the scorer's score SHALL increment by 1 and its point pulse SHALL assert in the SCORED cycle; scores SHALL saturate at 99.
REQ-022 SCORED SHALL last exactly 1 cycle, and ball_recenter SHALL pulse in that cycle.
REQ-023 On entry to SERVE from IDLE or GAME_OVER, ball_recenter SHALL also pulse for one cycle.
REQ-024 serve_dir SHALL toward the player who lost the last point (left exit -> 0); after a restart it SHALL be 1.
REQ-025 The PAUSE counter SHALL be 8 bits, clear on PAUSE entry, and increment only on frame_tick; the transition SHALL occur on the tick making the count PAUSE_FRAMES.
REQ-026 frame_tick coinciding with the SCORED cycle SHALL not be counted.
REQ-027 When game_over=1, winner SHALL hold the scorer of the final point.
REQ-028 All outputs SHALL be registered, with latency one cycle from the sampled input to the output.

Reset
REQ-029 Reset SHALL override all other inputs in the same cycle, including an exit or start.
REQ-030 Reset values: state IDLE, scores 0, counter 0, ball_enable 0, ball_recenter 0, point pulses 0, serve_dir 1, game_over 0, winner 0.
REQ-031 Reset mid-PAUSE or mid-PLAY SHALL abandon the rally without awarding a point.

Structure
REQ-032 Package rally_pkg SHALL hold the state enum, SCORE_W=7, SCORE_MAX=99 and PAUSE_W=8.
REQ-033 One sub-module, score_counter (saturating 7-bit counter with inc and clr), SHALL be instantiated twice.

Verification
REQ-034 Reset, then start=1 -> SERVE with one recenter pulse; first frame_tick -> ball_enable=1.
REQ-035 In PLAY, hold ball_x=x_coords_min-1 for 50 cycles -> score1=1, exactly one point_p1 pulse, serve_dir=0.
REQ-036 With PAUSE_FRAMES=3, after a point -> SERVE entered on the 3rd frame_tick, with ticks spaced 5 cycles apart.
REQ-037 With WIN_SCORE=2, two right exits -> score2=2, game_over=1, winner=1; start -> scores 0, SERVE.
REQ-038 Assert reset in the same cycle as a right exit -> score2 stays 0, no point_p2, state IDLE.
REQ-039 Force score1=99 via WIN_SCORE=99 sequence boundary -> game_over at 99; no wrap to 0.
